// File: rtl/mips_isa_pkg.sv
// Shared MIPS opcode/funct table and request-op numbering, used by both the
// control decoder and the instruction encoder/loader.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_ANDI = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,
        OP_LW   = 4'd9,
        OP_SW   = 4'd10,
        OP_J    = 4'd11
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_word_encode.sv
// Combinational encoder: symbolic op + register/immediate fields -> 32-bit
// MIPS instruction word, flagging op codes outside the supported set.
module instr_word_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FUNCT_ADD};
            OP_SUB:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FUNCT_SUB};
            OP_AND:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FUNCT_AND};
            OP_OR:   word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FUNCT_OR};
            OP_SLT:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'b00000, FUNCT_SLT};
            OP_ADDI: word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
            OP_ANDI: word_o = {OPC_ANDI, rs_i, rt_i, imm_i};
            OP_BEQ:  word_o = {OPC_BEQ,  rs_i, rt_i, imm_i};
            OP_BNE:  word_o = {OPC_BNE,  rs_i, rt_i, imm_i};
            OP_LW:   word_o = {OPC_LW,   rs_i, rt_i, imm_i};
            OP_SW:   word_o = {OPC_SW,   rs_i, rt_i, imm_i};
            OP_J:    word_o = {OPC_J, target_i};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction requests, encodes them and writes them one by
// one into instruction memory, tracking word count and sticky error flags.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    input  logic [25:0]       req_target,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              done,
    output logic              err_illegal,
    output logic              err_wrap,
    output logic [ADDR_W:0]   instr_count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q;
    logic                ready_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [31:0]         wdata_q;
    logic                done_q;
    logic                err_illegal_q;
    logic                err_wrap_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     count_d;
    logic                last_q;

    logic [31:0]         enc_word;
    logic                enc_illegal;

    instr_word_encode u_encode (
        .op_i      (req_op),
        .rs_i      (req_rs),
        .rt_i      (req_rt),
        .rd_i      (req_rd),
        .imm_i     (req_imm),
        .target_i  (req_target),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // ready_q is only ever set in IDLE; masking with start lets start win
    // the cycle without the source seeing a completed handshake.
    assign req_ready   = ready_q & ~start;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign done        = done_q;
    assign err_illegal = err_illegal_q;
    assign err_wrap    = err_wrap_q;
    assign instr_count = count_q;

    always_comb begin
        addr_d  = addr_q + 1'b1;
        count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= BASE;
            wdata_q       <= '0;
            done_q        <= 1'b0;
            err_illegal_q <= 1'b0;
            err_wrap_q    <= 1'b0;
            count_q       <= '0;
            last_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q        <= BASE;
                        count_q       <= '0;
                        err_illegal_q <= 1'b0;
                        err_wrap_q    <= 1'b0;
                    end else if (req_valid) begin
                        if (enc_illegal) begin
                            err_illegal_q <= 1'b1;
                            if (req_last) begin
                                state_q <= ST_DONE;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            wdata_q <= enc_word;
                            we_q    <= 1'b1;
                            last_q  <= req_last;
                            ready_q <= 1'b0;
                            state_q <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (imem_ack) begin
                        we_q    <= 1'b0;
                        addr_q  <= addr_d;
                        count_q <= count_d;
                        if (addr_q == '1) begin
                            err_wrap_q <= 1'b1;
                        end
                        if (last_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized requests
// checked against an arithmetic encoding/addressing model.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // DUT A: default 8-bit address space
    logic        a_start = 0, a_valid = 0, a_last = 0, a_ack = 0;
    logic [3:0]  a_op = 0;
    logic [4:0]  a_rs = 0, a_rt = 0, a_rd = 0;
    logic [15:0] a_imm = 0;
    logic [25:0] a_tgt = 0;
    logic        a_ready, a_we, a_done, a_erri, a_errw;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_count;

    // DUT B: 2-bit address space for wrap behaviour
    logic        b_start = 0, b_valid = 0, b_last = 0, b_ack = 0;
    logic [3:0]  b_op = 0;
    logic [4:0]  b_rs = 0, b_rt = 0, b_rd = 0;
    logic [15:0] b_imm = 0;
    logic [25:0] b_tgt = 0;
    logic        b_ready, b_we, b_done, b_erri, b_errw;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_count;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start),
        .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
        .req_rs(a_rs), .req_rt(a_rt), .req_rd(a_rd), .req_imm(a_imm),
        .req_target(a_tgt), .req_last(a_last),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .imem_ack(a_ack),
        .done(a_done), .err_illegal(a_erri), .err_wrap(a_errw), .instr_count(a_count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start),
        .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
        .req_rs(b_rs), .req_rt(b_rt), .req_rd(b_rd), .req_imm(b_imm),
        .req_target(b_tgt), .req_last(b_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .imem_ack(b_ack),
        .done(b_done), .err_illegal(b_erri), .err_wrap(b_errw), .instr_count(b_count)
    );

    // Reference encoding built from field weights rather than bit concatenation.
    function automatic logic [31:0] model_word(int op, int rs, int rt, int rd, int imm, int tgt);
        int funct_tab[5] = '{32, 34, 36, 37, 42};
        int opc_tab[6]   = '{8, 12, 4, 5, 35, 43};
        longint w;
        if (op < 5)
            w = longint'(rs) * (2**21) + longint'(rt) * (2**16) + longint'(rd) * (2**11) + funct_tab[op];
        else if (op < 11)
            w = longint'(opc_tab[op-5]) * (2**26) + longint'(rs) * (2**21) + longint'(rt) * (2**16) + imm;
        else
            w = 2 * longint'(2**26) + tgt;
        return w[31:0];
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
    endtask

    task automatic a_drive(input int op, input int rs, input int rt, input int rd,
                           input int imm, input int tgt, input logic last);
        a_valid = 1'b1;
        a_op = op[3:0]; a_rs = rs[4:0]; a_rt = rt[4:0]; a_rd = rd[4:0];
        a_imm = imm[15:0]; a_tgt = tgt[25:0]; a_last = last;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        nvec++; if (a_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b exp 1", a_ready); end
        nvec++; if (a_we !== 1'b0) begin nerr++; $display("FAIL reset_we got %b exp 0", a_we); end
        nvec++; if (a_addr !== 8'd0) begin nerr++; $display("FAIL reset_addr got %h exp 00", a_addr); end
        nvec++; if (a_wdata !== 32'd0) begin nerr++; $display("FAIL reset_wdata got %h exp 0", a_wdata); end
        nvec++; if ({a_done, a_erri, a_errw} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b exp 000", {a_done, a_erri, a_errw}); end
        nvec++; if (a_count !== 9'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", a_count); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_add_same_cycle();
        a_drive(0, 1, 2, 3, 16'hABCD, 26'h3FFFFFF, 1'b0);
        cyc();
        a_valid = 1'b0;
        nvec++; if (a_we !== 1'b1) begin nerr++; $display("FAIL add_we got %b exp 1", a_we); end
        nvec++; if (a_addr !== 8'd0) begin nerr++; $display("FAIL add_addr got %h exp 00", a_addr); end
        nvec++; if (a_wdata !== 32'h00221820) begin nerr++; $display("FAIL add_wdata got %h exp 00221820", a_wdata); end
        nvec++; if (a_ready !== 1'b0) begin nerr++; $display("FAIL add_ready_busy got %b exp 0", a_ready); end
        a_ack = 1'b1;
        cyc();
        a_ack = 1'b0;
        nvec++; if (a_we !== 1'b0) begin nerr++; $display("FAIL add_we_drop got %b exp 0", a_we); end
        nvec++; if (a_count !== 9'd1) begin nerr++; $display("FAIL add_count got %0d exp 1", a_count); end
        nvec++; if (a_addr !== 8'd1) begin nerr++; $display("FAIL add_addr_next got %h exp 01", a_addr); end
        nvec++; if (a_done !== 1'b0) begin nerr++; $display("FAIL add_no_done got %b exp 0", a_done); end
    endtask

    task automatic test_lw_beq_delayed();
        a_pulse_start();
        a_drive(9, 29, 8, 0, 16'h0004, 0, 1'b0);
        cyc();
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++; if ({a_we, a_addr, a_wdata} !== {1'b1, 8'd0, 32'h8FA80004}) begin
                nerr++; $display("FAIL lw_hold%0d got we=%b addr=%h data=%h exp 1/00/8fa80004", i, a_we, a_addr, a_wdata); end
            if (i < 2) cyc();
        end
        a_ack = 1'b1;
        cyc();
        a_ack = 1'b0;
        nvec++; if ({a_we, a_done, a_ready} !== 3'b001) begin nerr++; $display("FAIL lw_after got we/done/ready=%b exp 001", {a_we, a_done, a_ready}); end
        a_drive(7, 4, 5, 17, 16'hFFFF, 26'h155, 1'b1);
        cyc();
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++; if ({a_we, a_addr, a_wdata} !== {1'b1, 8'd1, 32'h1085FFFF}) begin
                nerr++; $display("FAIL beq_hold%0d got we=%b addr=%h data=%h exp 1/01/1085ffff", i, a_we, a_addr, a_wdata); end
            nvec++; if (a_done !== 1'b0) begin nerr++; $display("FAIL beq_early_done%0d got %b exp 0", i, a_done); end
            if (i < 2) cyc();
        end
        a_ack = 1'b1;
        cyc();
        a_ack = 1'b0;
        nvec++; if ({a_done, a_we, a_ready} !== 3'b100) begin nerr++; $display("FAIL beq_done got done/we/ready=%b exp 100", {a_done, a_we, a_ready}); end
        nvec++; if (a_count !== 9'd2) begin nerr++; $display("FAIL beq_count got %0d exp 2", a_count); end
        cyc();
        nvec++; if ({a_done, a_ready} !== 2'b01) begin nerr++; $display("FAIL done_pulse got done/ready=%b exp 01", {a_done, a_ready}); end
        nvec++; if (a_addr !== 8'd2) begin nerr++; $display("FAIL addr_no_rewind got %h exp 02", a_addr); end
    endtask

    task automatic test_jump();
        a_drive(11, 31, 31, 31, 16'hFFFF, 26'h0000100, 1'b0);
        cyc();
        a_valid = 1'b0;
        nvec++; if (a_wdata !== 32'h08000100) begin nerr++; $display("FAIL j_wdata got %h exp 08000100", a_wdata); end
        nvec++; if (a_addr !== 8'd2) begin nerr++; $display("FAIL j_addr got %h exp 02", a_addr); end
        a_ack = 1'b1;
        cyc();
        a_ack = 1'b0;
    endtask

    task automatic test_illegal();
        a_drive(13, 1, 2, 3, 4, 5, 1'b0);
        cyc();
        a_valid = 1'b0;
        nvec++; if (a_we !== 1'b0) begin nerr++; $display("FAIL ill_we got %b exp 0", a_we); end
        nvec++; if (a_erri !== 1'b1) begin nerr++; $display("FAIL ill_err got %b exp 1", a_erri); end
        nvec++; if (a_ready !== 1'b1) begin nerr++; $display("FAIL ill_ready got %b exp 1", a_ready); end
        a_drive(1, 7, 8, 9, 0, 0, 1'b0);
        cyc();
        a_valid = 1'b0;
        a_ack = 1'b1;
        cyc();
        a_ack = 1'b0;
        nvec++; if (a_erri !== 1'b1) begin nerr++; $display("FAIL ill_sticky got %b exp 1", a_erri); end
        a_pulse_start();
        nvec++; if (a_erri !== 1'b0) begin nerr++; $display("FAIL ill_clear got %b exp 0", a_erri); end
        nvec++; if ({a_addr, a_count} !== {8'd0, 9'd0}) begin nerr++; $display("FAIL start_rewind got addr=%h count=%0d exp 00/0", a_addr, a_count); end
    endtask

    task automatic test_start_priority();
        a_drive(14, 0, 0, 0, 0, 0, 1'b0);
        cyc();
        a_valid = 1'b0;
        a_start = 1'b1;
        a_drive(0, 1, 2, 3, 0, 0, 1'b0);
        #1;
        nvec++; if (a_ready !== 1'b0) begin nerr++; $display("FAIL sp_ready got %b exp 0", a_ready); end
        cyc();
        a_start = 1'b0;
        a_valid = 1'b0;
        nvec++; if (a_we !== 1'b0) begin nerr++; $display("FAIL sp_no_accept got %b exp 0", a_we); end
        nvec++; if (a_erri !== 1'b0) begin nerr++; $display("FAIL sp_err_clear got %b exp 0", a_erri); end
        cyc();
        nvec++; if ({a_we, a_ready} !== 2'b01) begin nerr++; $display("FAIL sp_idle got we/ready=%b exp 01", {a_we, a_ready}); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            b_valid = 1'b1; b_op = 4'd2; b_rs = 5'(i); b_rt = 5'd3; b_rd = 5'd4; b_last = 1'b0;
            cyc();
            b_valid = 1'b0;
            nvec++; if ({b_we, b_addr} !== {1'b1, 2'(i % 4)}) begin
                nerr++; $display("FAIL wrap_addr%0d got we=%b addr=%0d exp 1/%0d", i, b_we, b_addr, i % 4); end
            b_ack = 1'b1;
            cyc();
            b_ack = 1'b0;
            nvec++; if (b_errw !== (i >= 3)) begin nerr++; $display("FAIL wrap_err%0d got %b exp %b", i, b_errw, i >= 3); end
            nvec++; if (b_count !== 3'((i + 1 > 4) ? 4 : i + 1)) begin
                nerr++; $display("FAIL wrap_count%0d got %0d exp %0d", i, b_count, (i + 1 > 4) ? 4 : i + 1); end
        end
    endtask

    task automatic test_random();
        int n = 0;
        logic model_erri = 1'b0;
        a_pulse_start();
        for (int k = 0; k < 40; k++) begin
            int op, rs, rt, rd, imm, tgt, dly, expc;
            logic last;
            op   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
            rs   = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
            imm  = $urandom_range(0, 65535);
            tgt  = $urandom_range(0, 32'h3FFFFFF);
            last = ($urandom_range(0, 5) == 0);
            dly  = $urandom_range(0, 3);
            a_drive(op, rs, rt, rd, imm, tgt, last);
            cyc();
            a_valid = 1'b0;
            if (op < 12) begin
                nvec++; if ({a_we, a_addr, a_wdata} !== {1'b1, 8'(n % 256), model_word(op, rs, rt, rd, imm, tgt)}) begin
                    nerr++; $display("FAIL rnd%0d_write op=%0d got we=%b addr=%h data=%h exp 1/%h/%h",
                                     k, op, a_we, a_addr, a_wdata, 8'(n % 256), model_word(op, rs, rt, rd, imm, tgt)); end
                for (int d = 0; d < dly; d++) begin
                    cyc();
                    nvec++; if (a_we !== 1'b1) begin nerr++; $display("FAIL rnd%0d_hold got %b exp 1", k, a_we); end
                end
                a_ack = 1'b1;
                cyc();
                a_ack = 1'b0;
                n++;
                expc = (n > 256) ? 256 : n;
                nvec++; if ({a_we, a_count} !== {1'b0, 9'(expc)}) begin
                    nerr++; $display("FAIL rnd%0d_ack got we=%b count=%0d exp 0/%0d", k, a_we, a_count, expc); end
            end else begin
                model_erri = 1'b1;
                nvec++; if (a_we !== 1'b0) begin nerr++; $display("FAIL rnd%0d_illwe got %b exp 0", k, a_we); end
            end
            nvec++; if ({a_done, a_erri} !== {last, model_erri}) begin
                nerr++; $display("FAIL rnd%0d_flags got done=%b erri=%b exp %b/%b", k, a_done, a_erri, last, model_erri); end
            if (last) cyc();
        end
    endtask

    task automatic test_reset_mid_write();
        a_drive(3, 5, 6, 7, 0, 0, 1'b0);
        cyc();
        a_valid = 1'b0;
        nvec++; if (a_we !== 1'b1) begin nerr++; $display("FAIL rmw_we_pre got %b exp 1", a_we); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (a_we !== 1'b0) begin nerr++; $display("FAIL rmw_async_we got %b exp 0", a_we); end
        nvec++; if ({a_addr, a_count, a_wdata} !== {8'd0, 9'd0, 32'd0}) begin
            nerr++; $display("FAIL rmw_async_regs got addr=%h count=%0d data=%h exp 00/0/0", a_addr, a_count, a_wdata); end
        cyc();
        rst = 1'b0;
        cyc();
        nvec++; if ({a_ready, a_we, a_done} !== 3'b100) begin nerr++; $display("FAIL rmw_idle got ready/we/done=%b exp 100", {a_ready, a_we, a_done}); end
        nvec++; if ({a_addr, a_count} !== {8'd0, 9'd0}) begin nerr++; $display("FAIL rmw_regs got addr=%h count=%0d exp 00/0", a_addr, a_count); end
    endtask

    initial begin
        test_reset();
        test_add_same_cycle();
        test_lw_beq_delayed();
        test_jump();
        test_illegal();
        test_start_priority();
        test_wrap();
        test_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
